// File: rtl/uart_transceiver.sv
// Full-duplex 8N1-style UART; rx valid 1 cycle after last mid-stop sample, tx start bit 1 cycle after accept.
// No queueing: tx requests while busy are dropped. `UART_RX_BREAK_EN enables rx BREAK detection.
module uart_transceiver #(
  parameter int CLK_HZ       = 12_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_break,
  output logic                    uart_txd,
  input  logic                    uart_tx_en,
  output logic                    uart_tx_busy,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW = $clog2(CYCLES_PER_BIT + 1);
  localparam int BW = $clog2(PAYLOAD_BITS + STOP_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------- receive path ----------------
  logic                    rx_sync1, rx_line;
  logic [1:0]              rx_state;
  logic [CW-1:0]           rx_cnt;
  logic [BW-1:0]           rx_bits;
  logic [PAYLOAD_BITS-1:0] rx_shift;
  logic                    rx_stop_ok;
  logic                    rx_wait_high;
`ifdef UART_RX_BREAK_EN
  logic                    rx_stop_hi;
  logic                    rx_break_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_sync1 <= 1'b1;
      rx_line  <= 1'b1;
    end else begin
      rx_sync1 <= uart_rxd;
      rx_line  <= rx_sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_bits       <= '0;
      rx_shift      <= '0;
      rx_stop_ok    <= 1'b1;
      rx_wait_high  <= 1'b0;
      uart_rx_valid <= 1'b0;
      uart_rx_data  <= '0;
`ifdef UART_RX_BREAK_EN
      rx_stop_hi    <= 1'b0;
      rx_break_q    <= 1'b0;
`endif
    end else begin
      uart_rx_valid <= 1'b0;
`ifdef UART_RX_BREAK_EN
      rx_break_q    <= 1'b0;
`endif
      if (!uart_rx_en) begin
        // Abort; re-arm only after the line is seen idle so a mid-frame low is not taken as a start.
        rx_state     <= S_IDLE;
        rx_cnt       <= '0;
        rx_wait_high <= 1'b1;
      end else begin
        case (rx_state)
          S_IDLE: begin
            rx_cnt <= '0;
            if (rx_wait_high) begin
              if (rx_line) rx_wait_high <= 1'b0;
            end else if (!rx_line) begin
              rx_state <= S_START;
            end
          end
          S_START: begin
            if (rx_cnt == HALF_LAST) begin
              rx_cnt   <= '0;
              rx_bits  <= '0;
              rx_state <= rx_line ? S_IDLE : S_DATA;
            end else begin
              rx_cnt <= rx_cnt + CW'(1);
            end
          end
          S_DATA: begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt   <= '0;
              rx_shift <= {rx_line, rx_shift[PAYLOAD_BITS-1:1]};
              if (rx_bits == DATA_LAST) begin
                rx_bits    <= '0;
                rx_stop_ok <= 1'b1;
`ifdef UART_RX_BREAK_EN
                rx_stop_hi <= 1'b0;
`endif
                rx_state   <= S_STOP;
              end else begin
                rx_bits <= rx_bits + BW'(1);
              end
            end else begin
              rx_cnt <= rx_cnt + CW'(1);
            end
          end
          default: begin
            if (rx_cnt == BIT_LAST) begin
              rx_cnt <= '0;
              if (rx_bits == STOP_LAST) begin
                rx_state <= S_IDLE;
                if (rx_stop_ok && rx_line) begin
                  uart_rx_data  <= rx_shift;
                  uart_rx_valid <= 1'b1;
                end else begin
                  rx_wait_high <= 1'b1;
`ifdef UART_RX_BREAK_EN
                  if (rx_shift == '0 && !rx_stop_hi && !rx_line) rx_break_q <= 1'b1;
`endif
                end
              end else begin
                rx_bits    <= rx_bits + BW'(1);
                rx_stop_ok <= rx_stop_ok & rx_line;
`ifdef UART_RX_BREAK_EN
                rx_stop_hi <= rx_stop_hi | rx_line;
`endif
              end
            end else begin
              rx_cnt <= rx_cnt + CW'(1);
            end
          end
        endcase
      end
    end
  end

`ifdef UART_RX_BREAK_EN
  assign uart_rx_break = rx_break_q;
`else
  assign uart_rx_break = 1'b0;
`endif

  // ---------------- transmit path ----------------
  logic [1:0]              tx_state;
  logic [CW-1:0]           tx_cnt;
  logic [BW-1:0]           tx_bits;
  logic [PAYLOAD_BITS-1:0] tx_shift;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state     <= S_IDLE;
      tx_cnt       <= '0;
      tx_bits      <= '0;
      tx_shift     <= '0;
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx_cnt       <= '0;
          tx_bits      <= '0;
          uart_txd     <= 1'b1;
          uart_tx_busy <= 1'b0;
          if (uart_tx_en) begin
            tx_shift     <= uart_tx_data;
            uart_txd     <= 1'b0;
            uart_tx_busy <= 1'b1;
            tx_state     <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            uart_txd <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[PAYLOAD_BITS-1:1]};
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bits == DATA_LAST) begin
              tx_bits  <= '0;
              uart_txd <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_bits  <= tx_bits + BW'(1);
              uart_txd <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[PAYLOAD_BITS-1:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bits == STOP_LAST) begin
              tx_state     <= S_IDLE;
              uart_tx_busy <= 1'b0;
            end else begin
              tx_bits <= tx_bits + BW'(1);
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver: directed rx frames and tx requests, decoupled rx/tx monitors.
module tb_uart_transceiver;

  // Faster line rate keeps the run short; every timing expectation is derived from CPB.
  localparam int CLK_HZ    = 12_000_000;
  localparam int BIT_RATE  = 48_000;
  localparam int CPB       = CLK_HZ / BIT_RATE;
  localparam int STOP_BITS = 1;
`ifdef UART_RX_BREAK_EN
  localparam int EXP_BREAKS = 1;
`else
  localparam int EXP_BREAKS = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_en = 1'b1;
  logic       uart_rx_valid, uart_rx_break, uart_txd, uart_tx_busy;
  logic [7:0] uart_rx_data;
  logic       tb_tx_en = 1'b0;
  logic [7:0] tb_tx_data = 8'h00;
  logic       loop_en = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;
  int break_cnt = 0;
  logic tx_mon_en = 1'b1;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  assign tx_en   = loop_en ? uart_rx_valid : tb_tx_en;
  assign tx_data = loop_en ? uart_rx_data  : tb_tx_data;

  always #5 clk = ~clk;

  uart_transceiver #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk), .resetn(resetn),
    .uart_rxd(rxd), .uart_rx_en(rx_en),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_break(uart_rx_break),
    .uart_txd(uart_txd), .uart_tx_en(tx_en), .uart_tx_busy(uart_tx_busy), .uart_tx_data(tx_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at a negedge.
  task automatic drive_frame(input logic [7:0] d, input logic stop_v, input int gap);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_v;
    repeat (STOP_BITS * CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while ((rx_exp.size() != 0 || tx_exp.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (rx_exp.size() != 0 || tx_exp.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard not drained after %0d cycles (rx %0d, tx %0d left)",
               name, bound, rx_exp.size(), tx_exp.size());
    end
  endtask

  // Rx monitor: every valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (resetn && uart_rx_valid) begin
      if (rx_exp.size() == 0) check("rx_unexpected_valid", uart_rx_valid, 0);
      else check("rx_data", uart_rx_data, rx_exp.pop_front());
    end
    if (resetn && uart_rx_break) break_cnt++;
  end

  // Tx monitor: decode each frame on uart_txd at mid-bit points.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_mon_en && resetn && uart_txd === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", uart_txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd;
        end
        for (int s = 0; s < STOP_BITS; s++) begin
          repeat (CPB) @(negedge clk);
          check("tx_stop_bit", uart_txd, 1);
        end
        if (tx_exp.size() == 0) check("tx_unexpected_frame", {24'h0, b}, 32'hFFFF_FFFF);
        else check("tx_byte", b, tx_exp.pop_front());
      end
    end
  end

  initial begin
    int busy_cycles;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int bc0;
    // Reset values
    repeat (3) @(negedge clk);
    check("reset_txd", uart_txd, 1);
    check("reset_busy", uart_tx_busy, 0);
    check("reset_valid", uart_rx_valid, 0);
    check("reset_break", uart_rx_break, 0);
    check("reset_rx_data", uart_rx_data, 8'h00);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_txd", uart_txd, 1);
    check("idle_busy", uart_tx_busy, 0);

    // Tx 0xA5 with an ignored request mid-frame
    begin
      int busy_cycles;
      tb_tx_data = 8'hA5;
      tb_tx_en = 1'b1;
      tx_exp.push_back(8'hA5);
      @(posedge clk); #1;
      tb_tx_en = 1'b0;
      check("tx_start_latency", uart_txd, 0);
      check("tx_busy_rise", uart_tx_busy, 1);
      busy_cycles = 0;
      for (int i = 0; i < 20 * CPB && uart_tx_busy; i++) begin
        busy_cycles++;
        if (i == 5 * CPB) begin
          tb_tx_data = 8'h5A;
          tb_tx_en = 1'b1;
        end else begin
          tb_tx_en = 1'b0;
        end
        @(posedge clk); #1;
      end
      tb_tx_en = 1'b0;
      check("tx_busy_len", busy_cycles, 10 * CPB);
      repeat (2 * CPB) @(negedge clk);
      check("tx_idle_after", uart_txd, 1);
      check("tx_no_requeue", uart_tx_busy, 0);
      wait_drain("tx_a5", 2 * CPB);
    end

    // Rx 0x3C, then data held
    @(negedge clk);
    rx_exp.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1, CPB);
    wait_drain("rx_3c", 2 * CPB);
    repeat (1000) @(negedge clk);
    check("rx_hold_data", uart_rx_data, 8'h3C);

    // Glitch, framing error, then good 0x55
    rxd = 1'b0;
    repeat (CPB * 8 / 25) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    drive_frame(8'hF0, 1'b0, CPB);
    check("rx_frame_err_data", uart_rx_data, 8'h3C);
    rx_exp.push_back(8'h55);
    drive_frame(8'h55, 1'b1, CPB);
    wait_drain("rx_55", 2 * CPB);

    // Loopback echo; sender idles a few cycles between frames
    loop_en = 1'b1;
    rx_exp.push_back(8'h41);
    rx_exp.push_back(8'h42);
    tx_exp.push_back(8'h41);
    tx_exp.push_back(8'h42);
    drive_frame(8'h41, 1'b1, 4);
    drive_frame(8'h42, 1'b1, 4);
    wait_drain("echo", 14 * CPB);
    loop_en = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // BREAK: line low for 15 bit times
    bc0 = break_cnt;
    rxd = 1'b0;
    repeat (15 * CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("break_pulses", break_cnt - bc0, EXP_BREAKS);
    check("break_data_kept", uart_rx_data, 8'h42);

    // Reset mid-frame
    tx_mon_en = 1'b0;
    tb_tx_data = 8'h00;
    tb_tx_en = 1'b1;
    @(negedge clk);
    tb_tx_en = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("mid_frame_txd_low", uart_txd, 0);
    resetn = 1'b0;
    #1;
    check("rst_mid_txd", uart_txd, 1);
    check("rst_mid_busy", uart_tx_busy, 0);
    check("rst_mid_valid", uart_rx_valid, 0);
    check("rst_mid_break", uart_rx_break, 0);
    check("rst_mid_rx_data", uart_rx_data, 8'h00);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("post_rst_txd", uart_txd, 1);
    check("post_rst_busy", uart_tx_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
